change_dispenser: RTL and testbench

Change-return dispenser that consumes the 4-bit `cambio` amount produced by the vending FSM and pays it out one coin at a time through a four-phase handshake with the coin ejector. Greedy denomination selection (2-unit coins first, then 1-unit) against internal coin inventories. Reports completion, undelivered balance and faults (empty inventory, ejector timeout). Sits between the vending FSM's change output and the physical coin-ejector interface.

---
 rtl/change_dispenser.sv | 115 +++++++++++
 tb/tb_change_dispenser.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change-return dispenser: greedy 2-unit/1-unit payout of cambio via four-phase coin ejector handshake.
// Latency: busy/remaining valid one edge after cambio, first coin_req one edge later; done/error on exit edge.
// Backpressure: each coin waits on coin_ack (timeout ACK_TIMEOUT cycles); cambio/refill dropped while busy.
module change_dispenser #(
   parameter int COIN2_INIT  = 8,
   parameter int COIN1_INIT  = 8,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cambio,
   input  logic       refill,
   input  logic       coin_ack,
   output logic       coin_req,
   output logic       coin_sel,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] remaining,
   output logic [3:0] inv2,
   output logic [3:0] inv1
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECT   = 2'd1,
      REQ      = 2'd2,
      WAIT_LOW = 2'd3
   } state_t;

   localparam logic [3:0] INV2_RST = 4'(COIN2_INIT);
   localparam logic [3:0] INV1_RST = 4'(COIN1_INIT);
   // Compared before incrementing, so coin_req stays high exactly ACK_TIMEOUT cycles.
   localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state;
   logic [7:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         coin_req  <= 1'b0;
         coin_sel  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         remaining <= 4'd0;
         inv2      <= INV2_RST;
         inv1      <= INV1_RST;
         tmo_cnt   <= 8'd0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (cambio != 4'd0) begin
                  remaining <= cambio;
                  busy      <= 1'b1;
                  state     <= SELECT;
               end else if (refill) begin
                  inv2 <= INV2_RST;
                  inv1 <= INV1_RST;
               end
            end
            SELECT: begin
               if (remaining == 4'd0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (remaining >= 4'd2 && inv2 != 4'd0) begin
                  coin_sel <= 1'b1;
                  coin_req <= 1'b1;
                  tmo_cnt  <= 8'd0;
                  state    <= REQ;
               end else if (inv1 != 4'd0) begin
                  coin_sel <= 1'b0;
                  coin_req <= 1'b1;
                  tmo_cnt  <= 8'd0;
                  state    <= REQ;
               end else begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            REQ: begin
               if (coin_ack) begin
                  coin_req <= 1'b0;
                  if (coin_sel) begin
                     remaining <= remaining - 4'd2;
                     inv2      <= inv2 - 4'd1;
                  end else begin
                     remaining <= remaining - 4'd1;
                     inv1      <= inv1 - 4'd1;
                  end
                  state <= WAIT_LOW;
               end else if (tmo_cnt == TMO_LAST) begin
                  coin_req <= 1'b0;
                  error    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            WAIT_LOW: begin
               if (!coin_ack)
                  state <= SELECT;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a transaction-level greedy payout model.
module tb_change_dispenser;

   localparam int INIT2 = 8;
   localparam int INIT1 = 8;
   localparam int TMO   = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cambio;
   logic       refill;
   logic       coin_ack;
   logic       coin_req;
   logic       coin_sel;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] remaining;
   logic [3:0] inv2;
   logic [3:0] inv1;

   int errors = 0;
   int checks = 0;
   int m2 = INIT2;
   int m1 = INIT1;

   change_dispenser #(.COIN2_INIT(INIT2), .COIN1_INIT(INIT1), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .cambio(cambio), .refill(refill), .coin_ack(coin_ack),
      .coin_req(coin_req), .coin_sel(coin_sel), .busy(busy), .done(done), .error(error),
      .remaining(remaining), .inv2(inv2), .inv1(inv1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_refill();
      @(negedge clk); refill = 1'b1;
      @(negedge clk); refill = 1'b0;
      m2 = INIT2; m1 = INIT1;
      chk("refill_inv2", int'(inv2), m2);
      chk("refill_inv1", int'(inv1), m1);
   endtask

   // One payout: model predicts coin list and final state; ejector acks with random delays.
   task automatic payout(input logic [3:0] amt, input bit refl, input bit noack, input logic [3:0] poke);
      int r, a2, a1, ncoins, req_cycles, wcnt, dly_ack, dly_drop;
      bit finished, exp_done;
      bit exp_sel[$];
      r = int'(amt); a2 = m2; a1 = m1;
      exp_sel.delete();
      while (r > 0) begin
         if (r >= 2 && a2 > 0) begin exp_sel.push_back(1'b1); r -= 2; a2--; end
         else if (a1 > 0) begin exp_sel.push_back(1'b0); r -= 1; a1--; end
         else break;
      end
      if (noack) begin
         exp_done = 1'b0; r = int'(amt); a2 = m2; a1 = m1;
      end else begin
         exp_done = (r == 0);
      end

      @(negedge clk); cambio = amt; refill = refl;
      @(negedge clk); cambio = 4'd0; refill = 1'b0;
      chk("busy_start", int'(busy), 1);
      chk("rem_start", int'(remaining), int'(amt));

      ncoins = 0; req_cycles = 0; wcnt = 0; finished = 1'b0;
      dly_ack = $urandom_range(0, 3); dly_drop = $urandom_range(0, 3);
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(negedge clk);
         if (cyc == 1) cambio = poke;
         if (cyc == 2) cambio = 4'd0;
         if (done || error) begin
            finished = 1'b1;
         end else begin
            if (coin_req) req_cycles++;
            if (!noack && coin_req && !coin_ack) begin
               if (wcnt >= dly_ack) begin
                  coin_ack = 1'b1;
                  if (ncoins < exp_sel.size())
                     chk("coin_sel", int'(coin_sel), int'(exp_sel[ncoins]));
                  else
                     chk("extra_coin", ncoins, exp_sel.size());
                  ncoins++;
                  wcnt = 0; dly_drop = $urandom_range(0, 3);
               end else wcnt++;
            end else if (coin_ack && !coin_req) begin
               if (wcnt >= dly_drop) begin
                  coin_ack = 1'b0;
                  wcnt = 0; dly_ack = $urandom_range(0, 3);
               end else wcnt++;
            end
         end
      end
      coin_ack = 1'b0;
      if (!finished) begin
         chk("payout_hang", 0, 1);
      end else begin
         chk("done", int'(done), int'(exp_done));
         chk("error", int'(error), int'(!exp_done));
         chk("remaining", int'(remaining), r);
         chk("inv2", int'(inv2), a2);
         chk("inv1", int'(inv1), a1);
         chk("coin_count", ncoins, noack ? 0 : exp_sel.size());
         if (noack) chk("req_cycles", req_cycles, exp_sel.size() > 0 ? TMO : 0);
         @(negedge clk);
         chk("pulse_width", int'(done | error), 0);
         chk("busy_end", int'(busy), 0);
      end
      m2 = a2; m1 = a1;
   endtask

   initial begin
      reset = 1'b1; cambio = 4'd0; refill = 1'b0; coin_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_coin_req", int'(coin_req), 0);
      chk("rst_coin_sel", int'(coin_sel), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done | error), 0);
      chk("rst_remaining", int'(remaining), 0);
      chk("rst_inv2", int'(inv2), INIT2);
      chk("rst_inv1", int'(inv1), INIT1);

      payout(4'd5, 1'b0, 1'b0, 4'd0);

      // cambio=0 must not start a payout
      @(negedge clk); cambio = 4'd0;
      @(negedge clk);
      chk("zero_ignored", int'(busy), 0);

      do_refill();
      repeat (4) payout(4'd4, 1'b0, 1'b0, 4'd0);
      payout(4'd3, 1'b0, 1'b0, 4'd0);

      // inv1 exhausted with full inv2: partial payout ends in error
      do_refill();
      repeat (8) payout(4'd1, 1'b0, 1'b0, 4'd0);
      payout(4'd3, 1'b0, 1'b0, 4'd0);

      do_refill();
      payout(4'd2, 1'b0, 1'b1, 4'd0);
      payout(4'd3, 1'b0, 1'b0, 4'd4);

      // reset while a coin request is outstanding
      @(negedge clk); cambio = 4'd4;
      @(negedge clk); cambio = 4'd0;
      for (int i = 0; i < 10 && !coin_req; i++) @(negedge clk);
      chk("req_before_reset", int'(coin_req), 1);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      m2 = INIT2; m1 = INIT1;
      chk("midrst_coin_req", int'(coin_req), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_remaining", int'(remaining), 0);
      chk("midrst_inv2", int'(inv2), INIT2);
      chk("midrst_inv1", int'(inv1), INIT1);

      payout(4'd7, 1'b0, 1'b0, 4'd0);
      do_refill();
      payout(4'd3, 1'b0, 1'b0, 4'd0);
      payout(4'd1, 1'b1, 1'b0, 4'd0);

      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 3) == 0) do_refill();
         payout(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
